adder_rr_arbiter: RTL and testbench
===================================

// Module: adder_rr_arbiter
// PURPOSE
//   Shares one W-bit adder between N_REQ requesters (PE accumulate lanes) in the TPU datapath.
//   Round-robin arbitration, valid/ready request and response handshakes.
//   Registers the operands, the sum, the carry and the winner id.
//   Sits between the PE array lanes and the single shared adder resource.
// PARAMETERS
//   N_REQ  4                 number of requesters (>=2)
//   W      6                 operand/sum width
//   IDW    $clog2(N_REQ)     requester id width (derived; not overridden)
// PORTS
//   clk        in   1         single clock; all flops on posedge
//   rst_n      in   1         asynchronous, active-low reset
//   req_valid  in   N_REQ     per-requester request valid
//   req_a      in   N_REQ*W   operand A, lane i at [i*W +: W]
//   req_b      in   N_REQ*W   operand B, lane i at [i*W +: W]
//   req_ready  out  N_REQ     one-hot accept strobe (at most one bit set)
//   rsp_valid  out  1         result valid
//   rsp_ready  in   1         result consumer ready
//   rsp_sum    out  W         (a+b) mod 2^W
//   rsp_carry  out  1         bit W of a+b
//   rsp_id     out  IDW       index of the requester that produced this result
//   busy       out  1         high in any state other than S_IDLE
// BEHAVIOUR
//   Reset: state=S_INIT, ptr=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0,
//     req_ready=0, busy=1. Reset mid-operation discards any pending op/result.
//   FSM (registered state):
//     S_INIT  one cycle after reset release, req_ready=0 -> S_IDLE
//     S_IDLE  win = first i with req_valid[i], scanning ptr,ptr+1..N_REQ-1,0..ptr-1;
//             req_ready = onehot(win) combinationally (0 if no req_valid);
//             on accept: latch a,b,win into op regs -> S_EXEC
//     S_EXEC  adder evaluates latched operands; latch {carry,sum},id -> S_HOLD
//     S_HOLD  rsp_valid=1; sum/carry/id stable while rsp_valid&&!rsp_ready;
//             on rsp_ready: rsp_valid<=0, ptr<=(id==N_REQ-1)?0:id+1 -> S_IDLE
//   req_ready is 0 in every state except S_IDLE.
//     Requesters hold req_valid and operands until accepted.
//     Dropping req_valid before acceptance is legal; that request is simply not served.
//   Latency: accept at cycle T -> rsp_valid at T+2.
//     Peak throughput: one op per 3 cycles (rsp_ready tied high).
//   Arithmetic: sum = W+1-bit unsigned add, zero-extended operands.
//     Wrap-around is reported through rsp_carry only; no saturation.
//   Pointer: advances to one past the winner only on response handshake; wraps N_REQ-1 -> 0.
//   Simultaneous events:
//     - rsp_ready high in the first S_HOLD cycle -> 1-cycle rsp_valid pulse.
//     - New requests arriving in S_EXEC/S_HOLD wait; no pre-arbitration.
//   Outputs rsp_* are registered; req_ready is the only combinational output.
// STRUCTURE
//   Shared package tpu_arb_pkg:
//     state_t enum {S_INIT,S_IDLE,S_EXEC,S_HOLD};
//     function rr_pick(valid, ptr) returning index and found flag.
//   Sub-module rr_picker #(N_REQ): combinational round-robin select (valid, ptr -> onehot, idx, any).
//     Reused by later arbiters in the array.
//   Adder: inline W+1-bit add on the op regs, or instance of the team ripple adder
//     extended to expose carry.
// TESTING
//   1. ptr=0; req_valid=4'b0100, a2=5, b2=9 -> req_ready=4'b0100 same cycle;
//      rsp_valid at +2, sum=14, carry=0, id=2.
//   2. Overflow cases:
//      a=63, b=1  -> sum=0,  carry=1
//      a=40, b=40 -> sum=16, carry=1
//      a=0,  b=0  -> sum=0,  carry=0
//   3. All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; accepts every 3 cycles.
//   4. ptr=2, req_valid=4'b1010 -> serve 3 then 1; ptr=2 after both responses.
//   5. rsp_ready=0 for 5 cycles in S_HOLD -> rsp_* stable, req_ready=0, busy=1;
//      rsp_ready=1 -> S_IDLE next cycle.
//   6. Assert rst_n low in S_HOLD -> rsp_valid=0 immediately, ptr=0;
//      after release: req_ready=0 for 1 cycle (S_INIT), then accepts.
//   Assertions: $onehot0(req_ready); rsp_* stable while rsp_valid&&!rsp_ready;
//     no grant outside S_IDLE.

Source files
------------

// File: rtl/tpu_arb_pkg.sv
// Shared types and the round-robin selection function for the TPU datapath arbiters.
package tpu_arb_pkg;

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_IDLE = 2'd1,
      S_EXEC = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   localparam int MAX_REQ  = 32;
   localparam int PICK_IDW = 5;

   typedef struct packed {
      logic                found;
      logic [PICK_IDW-1:0] idx;
   } pick_t;

   // First set bit of valid[n-1:0] scanning ptr, ptr+1 .. n-1, 0 .. ptr-1.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                     input logic [PICK_IDW-1:0] ptr,
                                     input int                  n);
      pick_t r;
      int    pos;
      r = '0;
      // Walk the scan order backwards so the earliest hit is the last write.
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= n) pos = pos - n;
         if ((k < n) && valid[pos[PICK_IDW-1:0]]) begin
            r.found = 1'b1;
            r.idx   = pos[PICK_IDW-1:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: valid + pointer -> one-hot grant, index, any-valid.
module rr_picker
   import tpu_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         valid,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         onehot,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     any
);

   localparam int IDW = $clog2(N_REQ);

   logic [MAX_REQ-1:0] w_valid_ext;
   pick_t              w_pick;

   assign w_valid_ext = MAX_REQ'(valid);
   assign w_pick      = rr_pick(w_valid_ext, PICK_IDW'(ptr), N_REQ);
   assign any         = w_pick.found;
   assign idx         = w_pick.idx[IDW-1:0];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
         assign onehot[gi] = w_pick.found && (w_pick.idx == PICK_IDW'(gi));
      end
   endgenerate

endmodule

// File: rtl/adder_rr_arbiter.sv
// One W-bit adder shared by N_REQ PE accumulate lanes: round-robin grant,
// registered operands and registered {carry,sum,id} response.
module adder_rr_arbiter
   import tpu_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*W-1:0]       req_a,
   input  logic [N_REQ*W-1:0]       req_b,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [W-1:0]             rsp_sum,
   output logic                     rsp_carry,
   output logic [$clog2(N_REQ)-1:0] rsp_id,
   output logic                     busy
);

   localparam int IDW = $clog2(N_REQ);

   state_t         r_state;
   logic [IDW-1:0] r_ptr;
   logic [W-1:0]   r_op_a;
   logic [W-1:0]   r_op_b;
   logic [IDW-1:0] r_op_id;
   logic [W-1:0]   r_sum;
   logic           r_carry;
   logic [IDW-1:0] r_id;
   logic           r_rsp_valid;

   logic [N_REQ-1:0] w_onehot;
   logic [IDW-1:0]   w_win;
   logic             w_any;
   logic             w_accept;
   logic [W-1:0]     w_sel_a;
   logic [W-1:0]     w_sel_b;
   logic [W:0]       w_full_sum;
   logic [IDW-1:0]   w_ptr_next;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .valid  (req_valid),
      .ptr    (r_ptr),
      .onehot (w_onehot),
      .idx    (w_win),
      .any    (w_any)
   );

   // Grants are only offered while idle; requests seen elsewhere simply wait.
   assign req_ready  = (r_state == S_IDLE) ? w_onehot : '0;
   assign w_accept   = (r_state == S_IDLE) && w_any;
   assign w_sel_a    = req_a[w_win*W +: W];
   assign w_sel_b    = req_b[w_win*W +: W];
   assign w_full_sum = {1'b0, r_op_a} + {1'b0, r_op_b};
   assign w_ptr_next = (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_INIT;
         r_ptr       <= '0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_op_id     <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_id        <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            S_INIT: r_state <= S_IDLE;
            S_IDLE: begin
               if (w_accept) begin
                  r_op_a  <= w_sel_a;
                  r_op_b  <= w_sel_b;
                  r_op_id <= w_win;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               {r_carry, r_sum} <= w_full_sum;
               r_id             <= r_op_id;
               r_rsp_valid      <= 1'b1;
               r_state          <= S_HOLD;
            end
            S_HOLD: begin
               // Pointer moves past the winner only once its result is taken.
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_ptr       <= w_ptr_next;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_sum   = r_sum;
   assign rsp_carry = r_carry;
   assign rsp_id    = r_id;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: table vectors, directed corner sequences and a
// random phase, all checked against a transaction-level model on the falling edge.
module tb_adder_rr_arbiter;

   localparam int N  = 4;
   localparam int W  = 6;
   localparam int NW = N * W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [NW-1:0] req_a = '0;
   logic [NW-1:0] req_b = '0;
   logic [N-1:0]  req_ready;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [W-1:0]  rsp_sum;
   logic          rsp_carry;
   logic [1:0]    rsp_id;
   logic          busy;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   adder_rr_arbiter #(.N_REQ(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_carry (rsp_carry),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lane_val(input logic [NW-1:0] v, input int i);
      return int'(v[i*W +: W]);
   endfunction

   // Model: tracks one outstanding op, its age and the expected result.
   int m_ptr   = 0;
   bit m_busy  = 1'b0;
   bit m_init  = 1'b1;
   int m_age   = 0;
   int m_sum   = 0;
   int m_carry = 0;
   int m_id    = 0;

   always @(negedge clk) begin
      int win;
      int exp_ready;
      int raw;
      if (!rst_n) begin
         chk("rst_rsp_valid", int'(rsp_valid), 0);
         chk("rst_req_ready", int'(req_ready), 0);
         chk("rst_busy", int'(busy), 1);
         chk("rst_rsp_sum", int'(rsp_sum), 0);
         chk("rst_rsp_carry", int'(rsp_carry), 0);
         chk("rst_rsp_id", int'(rsp_id), 0);
         m_ptr  = 0;
         m_busy = 1'b0;
         m_init = 1'b1;
         m_age  = 0;
      end else begin
         win = -1;
         if (!m_busy && !m_init) begin
            for (int k = 0; k < N; k++) begin
               if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
         end
         exp_ready = (win >= 0) ? (1 << win) : 0;
         chk("req_ready", int'(req_ready), exp_ready);
         chk("onehot0", int'($onehot0(req_ready)), 1);
         chk("busy", int'(busy), int'(m_busy || m_init));
         chk("rsp_valid", int'(rsp_valid), int'(m_busy && m_age >= 2));
         if (m_busy && m_age >= 2) begin
            chk("rsp_sum", int'(rsp_sum), m_sum);
            chk("rsp_carry", int'(rsp_carry), m_carry);
            chk("rsp_id", int'(rsp_id), m_id);
         end
         if (m_init) begin
            m_init = 1'b0;
         end else if (win >= 0) begin
            raw     = lane_val(req_a, win) + lane_val(req_b, win);
            m_sum   = raw % (1 << W);
            m_carry = raw / (1 << W);
            m_id    = win;
            m_busy  = 1'b1;
            m_age   = 1;
         end else if (m_busy) begin
            if (m_age >= 2 && rsp_ready) begin
               m_busy = 1'b0;
               m_ptr  = (m_id + 1) % N;
            end else begin
               m_age++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input int a, input int b);
      req_a[i*W +: W] = W'(a);
      req_b[i*W +: W] = W'(b);
   endtask

   task automatic wait_grant(input int max_cyc, output int oh);
      oh = 0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            oh = int'(req_ready);
            break;
         end
      end
      chk("grant_seen", int'(oh != 0), 1);
   endtask

   task automatic wait_idle(input int max_cyc);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (!busy) begin
            seen = 1'b1;
            break;
         end
      end
      chk("idle_seen", int'(seen), 1);
   endtask

   // Single-lane op with rsp_ready high; returns at the negedge where rsp_valid shows.
   task automatic do_op(input int lane, input int a, input int b,
                        output int oh, output int lat,
                        output int sum, output int carry, output int id);
      tick();
      set_lane(lane, a, b);
      req_valid = N'(1 << lane);
      wait_grant(10, oh);
      tick();
      req_valid = '0;
      lat = 1;
      @(negedge clk);
      while (!rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      sum   = int'(rsp_sum);
      carry = int'(rsp_carry);
      id    = int'(rsp_id);
   endtask

   typedef struct {
      int lane;
      int a;
      int b;
      int sum;
      int carry;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int oh, lat, sum, carry, id;
      int g_idx[5];
      int g_cyc[5];
      int ng, cyc;

      vecs[0] = '{0, 63, 1, 0, 1};
      vecs[1] = '{1, 40, 40, 16, 1};
      vecs[2] = '{3, 0, 0, 0, 0};
      vecs[3] = '{2, 5, 9, 14, 0};
      vecs[4] = '{1, 63, 63, 62, 1};
      vecs[5] = '{0, 32, 31, 63, 0};

      rsp_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;

      // Basic op on lane 2, grant same cycle, result two cycles later.
      do_op(2, 5, 9, oh, lat, sum, carry, id);
      $display("op lane=2 a=5 b=9 -> grant=%0d lat=%0d sum=%0d carry=%0d id=%0d", oh, lat, sum, carry, id);
      chk("t1_grant", oh, 4);
      chk("t1_latency", lat, 2);
      chk("t1_sum", sum, 14);
      chk("t1_carry", carry, 0);
      chk("t1_id", id, 2);

      foreach (vecs[v]) begin
         do_op(vecs[v].lane, vecs[v].a, vecs[v].b, oh, lat, sum, carry, id);
         $display("op lane=%0d a=%0d b=%0d -> sum=%0d carry=%0d id=%0d",
                  vecs[v].lane, vecs[v].a, vecs[v].b, sum, carry, id);
         chk("vec_grant", oh, 1 << vecs[v].lane);
         chk("vec_latency", lat, 2);
         chk("vec_sum", sum, vecs[v].sum);
         chk("vec_carry", carry, vecs[v].carry);
         chk("vec_id", id, vecs[v].lane);
      end

      // All lanes requesting from ptr=0: order 0,1,2,3,0 with a 3-cycle spacing.
      tick();
      rst_n = 1'b0;
      tick();
      tick();
      for (int i = 0; i < N; i++) set_lane(i, 10 + i, 3 * i);
      req_valid = '1;
      rst_n     = 1'b1;
      ng  = 0;
      cyc = 0;
      while (ng < 5 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (req_ready != '0) begin
            g_idx[ng] = $clog2(int'(req_ready));
            g_cyc[ng] = cyc;
            ng++;
         end
      end
      chk("t3_grants", ng, 5);
      for (int i = 0; i < ng; i++) begin
         $display("grant #%0d lane=%0d cycle=%0d", i, g_idx[i], g_cyc[i]);
         chk("t3_order", g_idx[i], i % N);
         if (i > 0) chk("t3_spacing", g_cyc[i] - g_cyc[i-1], 3);
      end
      tick();
      req_valid = '0;
      wait_idle(10);

      // Serve lane 1 alone (ptr -> 2), then 4'b1010 must go 3 before 1.
      do_op(1, 7, 8, oh, lat, sum, carry, id);
      chk("t4_pre_sum", sum, 15);
      tick();
      set_lane(3, 60, 5);
      set_lane(1, 2, 2);
      req_valid = 4'b1010;
      wait_grant(10, oh);
      $display("ptr=2 valid=1010 first grant=%0d", oh);
      chk("t4_first", oh, 8);
      tick();
      req_valid = 4'b0010;
      wait_grant(10, oh);
      $display("ptr=2 valid=1010 second grant=%0d", oh);
      chk("t4_second", oh, 2);
      tick();
      req_valid = '0;
      wait_idle(10);

      // Pointer back at 2: all-valid grant is lane 2; then stall its response.
      tick();
      set_lane(2, 20, 50);
      set_lane(0, 1, 1);
      req_valid = '1;
      wait_grant(10, oh);
      $display("ptr check all-valid grant=%0d", oh);
      chk("t4_ptr2", oh, 4);
      tick();
      req_valid = 4'b1011;
      rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int s = 0; s < 6; s++) begin
         chk("t5_valid", int'(rsp_valid), 1);
         chk("t5_sum", int'(rsp_sum), 6);
         chk("t5_carry", int'(rsp_carry), 1);
         chk("t5_id", int'(rsp_id), 2);
         chk("t5_ready", int'(req_ready), 0);
         chk("t5_busy", int'(busy), 1);
         if (s < 5) @(negedge clk);
      end
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t5_valid_last", int'(rsp_valid), 1);
      @(negedge clk);
      $display("stall release: busy=%0d req_ready=%0d", busy, req_ready);
      chk("t5_idle", int'(busy), 0);
      chk("t5_next_grant", int'(req_ready), 8);

      // Reset while holding a result.
      tick();
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_in_hold", int'(rsp_valid), 1);
      tick();
      rst_n = 1'b0;
      #1;
      $display("reset in hold: rsp_valid=%0d busy=%0d", rsp_valid, busy);
      chk("t6_async_valid", int'(rsp_valid), 0);
      chk("t6_async_busy", int'(busy), 1);
      tick();
      req_valid = '1;
      rsp_ready = 1'b1;
      rst_n     = 1'b1;
      @(negedge clk);
      chk("t6_init_ready", int'(req_ready), 0);
      @(negedge clk);
      $display("after reset release: grant=%0d", req_ready);
      chk("t6_first_grant", int'(req_ready), 1);
      tick();
      req_valid = '0;
      wait_idle(10);

      // Random traffic, stalls and occasional resets; the model checks every cycle.
      for (int c = 0; c < 600; c++) begin
         tick();
         req_valid = N'($urandom);
         req_a     = NW'($urandom);
         req_b     = NW'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 149) != 0);
      end
      tick();
      rst_n     = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (6) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
